// File: rtl/perturbation_pkg.sv
// perturbation_pkg: stall mode encoding and LFSR tap constant for the rvalid stall FIFO
package perturbation_pkg;
    typedef enum logic [1:0] {
        NONE     = 2'd0,
        STANDARD = 2'd1,
        RANDOM   = 2'd2
    } stall_mode_e;
    // x^16+x^14+x^13+x^11+1 as a tap mask for the right-shifting Fibonacci form
    localparam logic [15:0] LFSR_POLY = 16'h002D;
endpackage

// File: rtl/riscv_stall_lfsr.sv
// riscv_stall_lfsr: 16-bit Fibonacci LFSR advanced once per request, used for random stall delays
module riscv_stall_lfsr
    import perturbation_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        adv_i,
    output logic [15:0] state_o
);
    logic [15:0] state_q, state_d;
    always_comb state_d = adv_i ? {^(state_q & LFSR_POLY), state_q[15:1]} : state_q;
    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= SEED;
        else state_q <= state_d;
    end
    assign state_o = state_q;
endmodule

// File: rtl/riscv_rvalid_stall_fifo.sv
// riscv_rvalid_stall_fifo: OBI response FIFO with per-entry stall delays; RANDOM mode needs RISCV_RVALID_STALL_RANDOM_EN
module riscv_rvalid_stall_fifo
    import perturbation_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          DEPTH     = 8,
    parameter int          DELAY_W   = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_i,
    input  logic                     gnt_i,
    output logic                     gnt_o,
    input  logic                     we_i,
    input  logic [DATA_W-1:0]        rdata_i,
    input  logic                     err_i,
    output logic [DATA_W-1:0]        rdata_o,
    output logic                     err_o,
    output logic                     rvalid_o,
    input  logic                     en_stall_i,
    input  logic [31:0]              stall_mode_i,
    input  logic [31:0]              max_stall_i,
    input  logic [31:0]              valid_stall_i,
    output logic [$clog2(DEPTH):0]   occupancy_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [DELAY_W-1:0] DMAX = '1;

    logic [PW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DEPTH-1:0]   we_q, we_d, err_q, err_d, data_ok_q, data_ok_d;
    logic [DELAY_W-1:0] delay_q [DEPTH];
    logic [DELAY_W-1:0] delay_d [DEPTH];
    logic [DATA_W-1:0]  data_q [DEPTH];
    logic [DATA_W-1:0]  data_d [DEPTH];
    logic               last_push_q, last_push_d;
    logic [AW-1:0]      last_idx_q, last_idx_d;
    logic [AW-1:0]      widx, hidx;
    logic               full, empty, push, pop, head_new, bypass;
    logic [DELAY_W-1:0] rnd_delay, push_delay;

    function automatic logic [DELAY_W-1:0] sat(input logic [31:0] x);
        return (x > 32'(DMAX)) ? DMAX : x[DELAY_W-1:0];
    endfunction

`ifdef RISCV_RVALID_STALL_RANDOM_EN
    logic [15:0] lfsr;
    logic        unused_lfsr;
    riscv_stall_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .adv_i   (push),
        .state_o (lfsr)
    );
    assign rnd_delay = (32'(lfsr[DELAY_W-1:0]) <= max_stall_i) ? lfsr[DELAY_W-1:0] : sat(max_stall_i);
    assign unused_lfsr = ^lfsr;
`else
    logic unused_cfg;
    assign rnd_delay = '0;
    assign unused_cfg = ^{max_stall_i, LFSR_SEED};
`endif

    assign widx  = wptr_q[AW-1:0];
    assign hidx  = rptr_q[AW-1:0];
    assign empty = wptr_q == rptr_q;
    assign full  = (widx == hidx) && (wptr_q[AW] != rptr_q[AW]);
    // during reset the pointers may still hold stale state, so keep the grant transparent
    assign gnt_o = gnt_i && !(rst_ni && full);
    assign push  = rst_ni && req_i && gnt_o;

    assign push_delay = !en_stall_i                          ? '0 :
                        stall_mode_i == 32'(STANDARD)        ? sat(valid_stall_i) :
                        stall_mode_i == 32'(RANDOM)          ? rnd_delay : '0;

    // the entry pushed last cycle is readable before its data lands in the array
    assign head_new    = last_push_q && (last_idx_q == hidx);
    assign bypass      = head_new && !we_q[hidx];
    assign rvalid_o    = rst_ni && !empty && (delay_q[hidx] == '0) && (data_ok_q[hidx] || head_new);
    assign pop         = rvalid_o;
    assign rdata_o     = !rvalid_o ? '0 : bypass ? rdata_i : data_q[hidx];
    assign err_o       = !rvalid_o ? 1'b0 : bypass ? err_i : err_q[hidx];
    assign occupancy_o = rst_ni ? wptr_q - rptr_q : '0;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        we_d        = we_q;
        err_d       = err_q;
        data_ok_d   = data_ok_q;
        delay_d     = delay_q;
        data_d      = data_q;
        last_push_d = push;
        last_idx_d  = widx;
        if (!empty && delay_q[hidx] != '0) delay_d[hidx] = delay_q[hidx] - DELAY_W'(1);
        if (last_push_q && !we_q[last_idx_q]) begin
            data_d[last_idx_q]    = rdata_i;
            err_d[last_idx_q]     = err_i;
            data_ok_d[last_idx_q] = 1'b1;
        end
        if (pop) rptr_d = rptr_q + PW'(1);
        if (push) begin
            wptr_d          = wptr_q + PW'(1);
            we_d[widx]      = we_i;
            err_d[widx]     = 1'b0;
            data_d[widx]    = '0;
            delay_d[widx]   = push_delay;
            data_ok_d[widx] = we_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            we_q        <= '0;
            err_q       <= '0;
            data_ok_q   <= '0;
            delay_q     <= '{default: '0};
            data_q      <= '{default: '0};
            last_push_q <= 1'b0;
            last_idx_q  <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            we_q        <= we_d;
            err_q       <= err_d;
            data_ok_q   <= data_ok_d;
            delay_q     <= delay_d;
            data_q      <= data_d;
            last_push_q <= last_push_d;
            last_idx_q  <= last_idx_d;
        end
    end
endmodule

// File: tb/tb_riscv_rvalid_stall_fifo.sv
// tb_riscv_rvalid_stall_fifo: random traffic checked against a queue model that derives each response cycle arithmetically
module tb_riscv_rvalid_stall_fifo;
    localparam int DEPTH = 8;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk_i = 1'b0, rst_ni = 1'b0, req_i = 1'b0, gnt_i = 1'b0, we_i = 1'b0, err_i = 1'b0;
    logic        en_stall_i = 1'b0;
    logic [31:0] rdata_i = '0, stall_mode_i = '0, max_stall_i = '0, valid_stall_i = '0;
    logic        gnt_o, err_o, rvalid_o;
    logic [31:0] rdata_o;
    logic [3:0]  occupancy_o;

    int checks = 0, failures = 0;

    always #5 clk_i = ~clk_i;

    riscv_rvalid_stall_fifo dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_i         (req_i),
        .gnt_i         (gnt_i),
        .gnt_o         (gnt_o),
        .we_i          (we_i),
        .rdata_i       (rdata_i),
        .err_i         (err_i),
        .rdata_o       (rdata_o),
        .err_o         (err_o),
        .rvalid_o      (rvalid_o),
        .en_stall_i    (en_stall_i),
        .stall_mode_i  (stall_mode_i),
        .max_stall_i   (max_stall_i),
        .valid_stall_i (valid_stall_i),
        .occupancy_o   (occupancy_o)
    );

    typedef struct {
        logic        we;
        logic [31:0] data;
        logic        err;
        int          delay;
        int          push_cyc;
    } ent_t;

    ent_t        q[$];
    int          cyc = 0;
    int          head_since = 0;
    logic [15:0] lfsr = SEED;
    bit          cap = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int exp_delay();
        int r;
        if (!en_stall_i) return 0;
        if (stall_mode_i == 32'd1) return (valid_stall_i > 32'd15) ? 15 : int'(valid_stall_i);
`ifdef RISCV_RVALID_STALL_RANDOM_EN
        if (stall_mode_i == 32'd2) begin
            r = int'(lfsr) % 16;
            return (32'(r) <= max_stall_i) ? r : ((max_stall_i > 32'd15) ? 15 : int'(max_stall_i));
        end
`endif
        return 0;
    endfunction

    // one clock cycle: drive, compare against the model mid-cycle, then advance model across the edge
    task automatic step(input bit rq, input bit gi, input bit w);
        bit   exp_v, do_push;
        int   start, d;
        ent_t e;
        req_i   = rq;
        gnt_i   = gi;
        we_i    = w;
        rdata_i = $urandom;
        err_i   = 1'($urandom_range(0, 1));
        #3;
        if (cap && q.size() > 0 && !q[$].we) begin
            q[$].data = rdata_i;
            q[$].err  = err_i;
        end
        exp_v = 1'b0;
        if (rst_ni && q.size() > 0) begin
            start = q[0].push_cyc + 1;
            if (head_since > start) start = head_since;
            exp_v = cyc >= start + q[0].delay;
        end
        check("gnt_o", 64'(gnt_o), 64'(gi && (!rst_ni || q.size() < DEPTH)));
        check("occupancy_o", 64'(occupancy_o), rst_ni ? 64'(q.size()) : 64'd0);
        check("rvalid_o", 64'(rvalid_o), 64'(exp_v));
        check("rdata_o", 64'(rdata_o), exp_v ? 64'(q[0].data) : 64'd0);
        check("err_o", 64'(err_o), exp_v ? 64'(q[0].err) : 64'd0);
        do_push = rst_ni && rq && gi && q.size() < DEPTH;
        d = exp_delay();
        @(posedge clk_i);
        if (!rst_ni) begin
            q.delete();
            head_since = 0;
            lfsr = SEED;
            cap = 1'b0;
        end else begin
            if (exp_v) begin
                void'(q.pop_front());
                head_since = cyc + 1;
            end
            if (do_push) begin
                e.we = w; e.data = '0; e.err = 1'b0; e.delay = d; e.push_cyc = cyc;
                q.push_back(e);
                lfsr = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            end
            cap = do_push;
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        rst_ni = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        rst_ni = 1'b1;
        en_stall_i = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        idle(3);
        en_stall_i = 1'b1; stall_mode_i = 32'd1; valid_stall_i = 32'd3;
        step(1'b1, 1'b1, 1'b0);
        idle(6);
        valid_stall_i = 32'd40;
        step(1'b1, 1'b1, 1'b0);
        idle(18);
        valid_stall_i = 32'd15;
        for (int i = 0; i < 30; i++) step(1'b1, 1'b1, 1'($urandom_range(0, 1)));
        idle(150);
        en_stall_i = 1'b0;
        for (int i = 0; i < 20; i++) step(1'b1, 1'($urandom_range(0, 3) != 0), i % 3 == 0);
        idle(5);
        en_stall_i = 1'b1; valid_stall_i = 32'd15;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        rst_ni = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        rst_ni = 1'b1;
        idle(20);
        for (int pass = 0; pass < 2; pass++) begin
            stall_mode_i = 32'd2; max_stall_i = 32'd5;
            for (int i = 0; i < 150; i++) step(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)));
            rst_ni = 1'b0;
            step(1'b0, 1'b1, 1'b0);
            rst_ni = 1'b1;
        end
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                en_stall_i    = 1'($urandom_range(0, 1));
                stall_mode_i  = 32'($urandom_range(0, 3));
                max_stall_i   = 32'($urandom_range(0, 20));
                valid_stall_i = ($urandom_range(0, 7) == 0) ? 32'd40 : 32'($urandom_range(0, 6));
            end
            rst_ni = $urandom_range(0, 250) != 0;
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        end
        rst_ni = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
